alu_result_mux_pipe: RTL and testbench
======================================

Name: alu_result_mux_pipe

Overview:
Parametrised, registered successor to the ALU result mux. Selects one of NUM_IN operand/result words by `sel` and registers the selection with a valid/ready handshake. A 2-entry skid buffer keeps full throughput under downstream back-pressure. Also produces zero, negative and select-error flags for the writeback/flag stage. Sits between the ALU functional units and the register-file writeback.

Parameters:
WIDTH, 32, data width of each input and of the output
NUM_IN, 10, number of selectable inputs (2..16)
SEL_W, 4, select width; must satisfy 2**SEL_W >= NUM_IN

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  synchronous active-low reset
in_data  input  NUM_IN*WIDTH  packed inputs; input i occupies bits [i*WIDTH +: WIDTH]
sel  input  SEL_W  input select
in_valid  input  1  upstream has a word to transfer
in_ready  output  1  block can accept a word this cycle
out_data  output  WIDTH  selected, registered word
out_zero  output  1  out_data == 0
out_neg  output  1  out_data[WIDTH-1]
out_sel_err  output  1  this word's sel was >= NUM_IN
out_valid  output  1  out_* fields are valid
out_ready  input  1  downstream accepts the word this cycle
err_clr  input  1  clears sticky error; present only with ALU_MUX_STICKY_ERR_EN
err_sticky  output  1  sticky select-error flag; present only with ALU_MUX_STICKY_ERR_EN

Behaviour:
- Transfers: input accepted when in_valid & in_ready at clk edge; output consumed when out_valid & out_ready at clk edge.
- Select:
  - sel < NUM_IN: word = in_data[sel*WIDTH +: WIDTH], sel_err=0.
  - sel >= NUM_IN: word = 0, sel_err=1.
  - Flags computed on the selected word before registering; stored with it.
- Storage: main register (drives out_*) and skid register, each holding {data, zero, neg, sel_err}.
- FSM states: EMPTY, ONE (main full), FULL (main and skid full).
  - EMPTY: accept -> ONE, main <= new word.
  - ONE, accept and no consume -> FULL, skid <= new word.
  - ONE, consume and no accept -> EMPTY.
  - ONE, accept and consume together -> ONE, main <= new word.
  - FULL, consume -> ONE, main <= skid.
  - FULL, no consume -> hold.
  - No accept is possible in FULL.
- in_ready = (state != FULL), driven from a register with no combinational path from out_ready.
- out_valid = (state != EMPTY).
- Latency: an accepted word appears on out_* on the next cycle when the block was EMPTY, or when it was ONE and consumed in the same cycle.
- Throughput: 1 word/cycle while out_ready=1. Ordering is strict FIFO.
- Stability: while out_valid=1 and out_ready=0, all out_* hold stable.
- Reset: when rst_n=0 at a clk edge:
  - state=EMPTY; out_valid=0, in_ready=1.
  - out_data=0, out_zero=0, out_neg=0, out_sel_err=0; skid cleared.
  - Words held in flight are discarded.
  - Inputs are ignored during reset; in_valid during reset is not accepted.
- X-safety: out_data must not depend on in_data when sel is out of range.

Optional Feature:
Macro ALU_MUX_STICKY_ERR_EN.
- Defined:
  - err_sticky sets on the edge where a word with sel_err=1 is accepted.
  - It stays set until err_clr=1 at a clk edge. Clear has priority over a same-cycle set.
  - Reset value 0.
- Undefined: err_clr and err_sticky ports do not exist; no sticky logic is generated.

Test Plan:
- Basic select, out_ready=1: in_data[0]=32'habcdefab, [1]=32'h0f0f0f0f, [8]=32'hffffffff. sel=0, 1, 8 on consecutive cycles with in_valid=1 -> out_data abcdefab, 0f0f0f0f, ffffffff on the 3 following cycles; out_neg=1,0,1; out_zero=0; in_ready constant 1.
- Out-of-range select: sel=4'hA or 4'hF with NUM_IN=10 -> out_data=0, out_zero=1, out_sel_err=1. With ALU_MUX_STICKY_ERR_EN, err_sticky=1 until err_clr pulses.
- Back-pressure: out_ready=0, push sel=0 then sel=1 -> in_ready=0 after the 2nd accept; out_data holds abcdefab. Raise out_ready -> abcdefab then 0f0f0f0f, no loss or duplication; in_ready returns to 1 one cycle after the first consume.
- Simultaneous accept and consume in ONE state: continuous streaming of 8 words with random sel < 10 -> output order matches input order, no bubbles.
- Reset mid-operation: block FULL, assert rst_n=0 for 1 cycle -> out_valid=0, in_ready=1, out_data=0 on the next edge; the next accepted word appears normally.
- Parameter sweep: WIDTH=8, NUM_IN=3, SEL_W=2, sel=3 -> sel_err=1, out_data=8'h00. Flags are correct for 8'h80 (neg=1) and 8'h00 (zero=1).

Source files
------------

// File: rtl/alu_result_mux_pipe.sv
// -----------------------------------------------------------------------------
// alu_result_mux_pipe
//
// Registered ALU result mux. Selects one of NUM_IN words by `sel`, computes
// zero / negative / select-error flags on the selected word, and hands the
// result downstream through a valid/ready handshake. A main register drives
// the outputs. A second "skid" register absorbs one extra word, so the
// upstream ready can come from a register and throughput stays at one word
// per cycle under back-pressure.
//
// Optional feature (macro ALU_MUX_STICKY_ERR_EN): a sticky select-error flag
// with a synchronous clear input.
//
// Ports:
//   clk         rising-edge clock
//   rst_n       synchronous active-low reset
//   in_data     NUM_IN packed words, word i at [i*WIDTH +: WIDTH]
//   sel         input select
//   in_valid    upstream offers a word
//   in_ready    block can accept a word this cycle (registered)
//   out_data    selected, registered word
//   out_zero    out_data == 0
//   out_neg     out_data[WIDTH-1]
//   out_sel_err sel of this word was >= NUM_IN
//   out_valid   out_* fields are valid
//   out_ready   downstream consumes the word this cycle
//   err_clr     clears err_sticky (ALU_MUX_STICKY_ERR_EN only)
//   err_sticky  sticky select-error flag (ALU_MUX_STICKY_ERR_EN only)
// -----------------------------------------------------------------------------
module alu_result_mux_pipe #(
   parameter int WIDTH  = 32,
   parameter int NUM_IN = 10,
   parameter int SEL_W  = 4
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [NUM_IN*WIDTH-1:0] in_data,
   input  logic [SEL_W-1:0]        sel,
   input  logic                    in_valid,
   output logic                    in_ready,
   output logic [WIDTH-1:0]        out_data,
   output logic                    out_zero,
   output logic                    out_neg,
   output logic                    out_sel_err,
   output logic                    out_valid,
`ifdef ALU_MUX_STICKY_ERR_EN
   input  logic                    err_clr,
   output logic                    err_sticky,
`endif
   input  logic                    out_ready
);

   localparam logic [1:0] EMPTY = 2'd0;
   localparam logic [1:0] ONE   = 2'd1;
   localparam logic [1:0] FULL  = 2'd2;

   typedef struct packed {
      logic [WIDTH-1:0] data;
      logic             zero;
      logic             neg;
      logic             sel_err;
   } word_t;

   logic [1:0]       state;
   logic [1:0]       state_nxt;
   logic             in_ready_q;
   word_t            main_q;
   word_t            skid_q;
   word_t            new_word;
   logic [WIDTH-1:0] sel_data;
   logic             sel_err;
   logic             accept;
   logic             consume;
   logic             load_main_new;
   logic             load_main_skid;
   logic             load_skid;

   // Compare sel against every legal index and never index in_data with
   // sel directly. An out-of-range select therefore reads none of in_data,
   // and the result is a clean zero.
   // NOTE: every signal gets a default before the loop. Without it, the
   // paths that match nothing would infer latches.
   always_comb begin
      sel_data = '0;
      sel_err  = 1'b1;
      for (int i = 0; i < NUM_IN; i++) begin
         if (sel == SEL_W'(i)) begin
            sel_data = in_data[i*WIDTH +: WIDTH];
            sel_err  = 1'b0;
         end
      end
   end

   always_comb begin
      new_word.data    = sel_data;
      new_word.zero    = (sel_data == '0);
      new_word.neg     = sel_data[WIDTH-1];
      new_word.sel_err = sel_err;
   end

   assign in_ready = in_ready_q;
   assign out_valid = (state != EMPTY);
   assign accept    = in_valid & in_ready_q;
   assign consume   = out_valid & out_ready;

   always_comb begin
      state_nxt      = state;
      load_main_new  = 1'b0;
      load_main_skid = 1'b0;
      load_skid      = 1'b0;
      case (state)
         EMPTY: begin
            if (accept) begin
               state_nxt     = ONE;
               load_main_new = 1'b1;
            end
         end
         ONE: begin
            if (accept && !consume) begin
               state_nxt = FULL;
               load_skid = 1'b1;
            end else if (!accept && consume) begin
               state_nxt = EMPTY;
            end else if (accept && consume) begin
               load_main_new = 1'b1;
            end
         end
         FULL: begin
            // in_ready is low here, so the only event is a consume.
            if (consume) begin
               state_nxt      = ONE;
               load_main_skid = 1'b1;
            end
         end
         default: state_nxt = EMPTY;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments only, so every
   // register samples the values from before the edge.
   // NOTE: both data registers are cleared on reset. out_data is observable
   // right after reset and must read zero.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= EMPTY;
         in_ready_q <= 1'b1;
         main_q     <= '0;
         skid_q     <= '0;
      end else begin
         state      <= state_nxt;
         // Register the decode of the next state. in_ready then has no
         // combinational path from out_ready.
         in_ready_q <= (state_nxt != FULL);
         if (load_main_new) begin
            main_q <= new_word;
         end else if (load_main_skid) begin
            main_q <= skid_q;
         end
         if (load_skid) begin
            skid_q <= new_word;
         end
      end
   end

   assign out_data    = main_q.data;
   assign out_zero    = main_q.zero;
   assign out_neg     = main_q.neg;
   assign out_sel_err = main_q.sel_err;

`ifdef ALU_MUX_STICKY_ERR_EN
   // Clear wins over a set in the same cycle.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         err_sticky <= 1'b0;
      end else if (err_clr) begin
         err_sticky <= 1'b0;
      end else if (accept && new_word.sel_err) begin
         err_sticky <= 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_alu_result_mux_pipe.sv
// -----------------------------------------------------------------------------
// tb_alu_result_mux_pipe
//
// Directed bench for alu_result_mux_pipe. It uses a 32-bit/10-input instance,
// plus an 8-bit/3-input instance for the narrow parameter set. Expected values
// are hand-computed constants or come from a small occupancy/FIFO model.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_alu_result_mux_pipe;

   logic         clk;
   logic         rst_n;
   logic [319:0] in_data;
   logic [3:0]   sel;
   logic         in_valid;
   logic         in_ready;
   logic [31:0]  out_data;
   logic         out_zero;
   logic         out_neg;
   logic         out_sel_err;
   logic         out_valid;
   logic         out_ready;
   logic         err_clr;
   logic         err_sticky;

   logic [23:0]  in_data_s;
   logic [1:0]   sel_s;
   logic         in_valid_s;
   logic         in_ready_s;
   logic [7:0]   out_data_s;
   logic         out_zero_s;
   logic         out_neg_s;
   logic         out_sel_err_s;
   logic         out_valid_s;
   logic         out_ready_s;
   logic         err_clr_s;
   logic         err_sticky_s;

   logic [31:0]  words [10];
   int           checks;
   int           failures;

   alu_result_mux_pipe #(.WIDTH(32), .NUM_IN(10), .SEL_W(4)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .in_data     (in_data),
      .sel         (sel),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .out_data    (out_data),
      .out_zero    (out_zero),
      .out_neg     (out_neg),
      .out_sel_err (out_sel_err),
      .out_valid   (out_valid),
`ifdef ALU_MUX_STICKY_ERR_EN
      .err_clr     (err_clr),
      .err_sticky  (err_sticky),
`endif
      .out_ready   (out_ready)
   );

   alu_result_mux_pipe #(.WIDTH(8), .NUM_IN(3), .SEL_W(2)) dut_s (
      .clk         (clk),
      .rst_n       (rst_n),
      .in_data     (in_data_s),
      .sel         (sel_s),
      .in_valid    (in_valid_s),
      .in_ready    (in_ready_s),
      .out_data    (out_data_s),
      .out_zero    (out_zero_s),
      .out_neg     (out_neg_s),
      .out_sel_err (out_sel_err_s),
      .out_valid   (out_valid_s),
`ifdef ALU_MUX_STICKY_ERR_EN
      .err_clr     (err_clr_s),
      .err_sticky  (err_sticky_s),
`endif
      .out_ready   (out_ready_s)
   );

`ifndef ALU_MUX_STICKY_ERR_EN
   assign err_sticky   = 1'b0;
   assign err_sticky_s = 1'b0;
`endif

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Advance one cycle and land 1 ns after the rising edge to sample.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_out(input string tag, input logic valid, input logic [31:0] data,
                            input logic zero, input logic neg, input logic err);
      check({tag, ".valid"}, out_valid, valid);
      check({tag, ".data"},  out_data,  data);
      check({tag, ".zero"},  out_zero,  zero);
      check({tag, ".neg"},   out_neg,   neg);
      check({tag, ".err"},   out_sel_err, err);
   endtask

   task automatic check_small(input string tag, input logic [7:0] data,
                              input logic zero, input logic neg, input logic err);
      check({tag, ".valid"}, out_valid_s, 1'b1);
      check({tag, ".data"},  out_data_s,  data);
      check({tag, ".zero"},  out_zero_s,  zero);
      check({tag, ".neg"},   out_neg_s,   neg);
      check({tag, ".err"},   out_sel_err_s, err);
   endtask

   function automatic logic [31:0] exp_word(input int s);
      return (s < 10) ? words[s] : 32'h0;
   endfunction

   initial begin
      logic [32:0] q[$];
      logic [31:0] e;
      int          s;
      int          occ;

      checks   = 0;
      failures = 0;

      words[0] = 32'habcdefab;
      words[1] = 32'h0f0f0f0f;
      words[2] = 32'h00000000;
      words[3] = 32'h80000000;
      words[4] = 32'h12345678;
      words[5] = 32'h7fffffff;
      words[6] = 32'hdeadbeef;
      words[7] = 32'h00000001;
      words[8] = 32'hffffffff;
      words[9] = 32'h55aa55aa;
      for (int i = 0; i < 10; i++) in_data[i*32 +: 32] = words[i];

      // Small instance: [0]=5a, [1]=80, [2]=00.
      in_data_s   = {8'h00, 8'h80, 8'h5a};
      sel_s       = 2'd0;
      in_valid_s  = 1'b0;
      out_ready_s = 1'b1;
      err_clr_s   = 1'b0;

      rst_n     = 1'b0;
      sel       = 4'd0;
      in_valid  = 1'b1;   // must be ignored while in reset
      out_ready = 1'b1;
      err_clr   = 1'b0;

      // ---- reset state ----
      tick();
      tick();
      check_out("reset", 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
      check("reset.in_ready", in_ready, 1'b1);
      check("reset.sticky", err_sticky, 1'b0);
      rst_n    = 1'b1;
      in_valid = 1'b0;
      tick();
      check("idle.valid", out_valid, 1'b0);

      // ---- basic select, out_ready=1 ----
      in_valid = 1'b1;
      sel = 4'd0;
      tick();
      check_out("sel0", 1'b1, 32'habcdefab, 1'b0, 1'b1, 1'b0);
      check("sel0.in_ready", in_ready, 1'b1);
      sel = 4'd1;
      tick();
      check_out("sel1", 1'b1, 32'h0f0f0f0f, 1'b0, 1'b0, 1'b0);
      check("sel1.in_ready", in_ready, 1'b1);
      sel = 4'd8;
      tick();
      check_out("sel8", 1'b1, 32'hffffffff, 1'b0, 1'b1, 1'b0);
      check("sel8.in_ready", in_ready, 1'b1);
      in_valid = 1'b0;
      tick();
      check("drain1.valid", out_valid, 1'b0);

      // ---- out-of-range select ----
      in_valid = 1'b1;
      sel = 4'hA;
      tick();
      check_out("selA", 1'b1, 32'h0, 1'b1, 1'b0, 1'b1);
      sel = 4'hF;
      tick();
      check_out("selF", 1'b1, 32'h0, 1'b1, 1'b0, 1'b1);
      in_valid = 1'b0;
      sel = 4'd0;
      tick();
      check("drain2.valid", out_valid, 1'b0);
`ifdef ALU_MUX_STICKY_ERR_EN
      check("sticky.set", err_sticky, 1'b1);
      tick();
      check("sticky.hold", err_sticky, 1'b1);
      // A same-cycle set and clear resolve to clear.
      in_valid = 1'b1;
      sel = 4'hB;
      err_clr = 1'b1;
      tick();
      in_valid = 1'b0;
      err_clr = 1'b0;
      check("sticky.clr", err_sticky, 1'b0);
      tick();
      check("sticky.after", err_sticky, 1'b0);
      sel = 4'd0;
`endif

      // ---- back-pressure ----
      out_ready = 1'b0;
      in_valid  = 1'b1;
      sel = 4'd0;
      tick();
      check_out("bp1", 1'b1, 32'habcdefab, 1'b0, 1'b1, 1'b0);
      check("bp1.in_ready", in_ready, 1'b1);
      sel = 4'd1;
      tick();
      check_out("bp2", 1'b1, 32'habcdefab, 1'b0, 1'b1, 1'b0);
      check("bp2.in_ready", in_ready, 1'b0);
      sel = 4'd8;   // offered while full: must not be taken
      tick();
      check_out("bp3", 1'b1, 32'habcdefab, 1'b0, 1'b1, 1'b0);
      check("bp3.in_ready", in_ready, 1'b0);
      in_valid  = 1'b0;
      out_ready = 1'b1;
      tick();
      check_out("bp4", 1'b1, 32'h0f0f0f0f, 1'b0, 1'b0, 1'b0);
      check("bp4.in_ready", in_ready, 1'b1);
      tick();
      check("bp5.valid", out_valid, 1'b0);

      // ---- continuous streaming, no bubbles ----
      in_valid = 1'b1;
      for (int k = 0; k < 8; k++) begin
         s   = int'($urandom_range(9));
         sel = 4'(s);
         e   = words[s];
         tick();
         check($sformatf("stream%0d.data", k), out_data, e);
         check($sformatf("stream%0d.valid", k), out_valid, 1'b1);
         check($sformatf("stream%0d.in_ready", k), in_ready, 1'b1);
      end
      in_valid = 1'b0;
      tick();
      check("stream.end", out_valid, 1'b0);

      // ---- random handshake against a FIFO model ----
      q.delete();
      for (int c = 0; c < 80; c++) begin
         occ = q.size();
         check($sformatf("rnd%0d.valid", c), out_valid, occ != 0);
         check($sformatf("rnd%0d.in_ready", c), in_ready, occ < 2);
         if (occ != 0) begin
            check($sformatf("rnd%0d.data", c), out_data, q[0][31:0]);
            check($sformatf("rnd%0d.err", c), out_sel_err, q[0][32]);
         end
         in_valid  = 1'($urandom_range(1));
         out_ready = 1'($urandom_range(1));
         s   = int'($urandom_range(11));
         sel = 4'(s);
         if (occ != 0 && out_ready) void'(q.pop_front());
         if (in_valid && occ < 2) q.push_back({(s >= 10), exp_word(s)});
         tick();
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      tick();
      tick();
      check("rnd.drain", out_valid, 1'b0);

      // ---- reset while full ----
      out_ready = 1'b0;
      in_valid  = 1'b1;
      sel = 4'd0;
      tick();
      sel = 4'd8;
      tick();
      check("prefull.in_ready", in_ready, 1'b0);
      rst_n = 1'b0;
      sel   = 4'd1;
      tick();
      check_out("midrst", 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
      check("midrst.in_ready", in_ready, 1'b1);
      rst_n     = 1'b1;
      out_ready = 1'b1;
      tick();
      check_out("postrst", 1'b1, 32'h0f0f0f0f, 1'b0, 1'b0, 1'b0);
      in_valid = 1'b0;
      tick();
      check("postrst.drain", out_valid, 1'b0);

      // ---- narrow parameter set ----
      check("small.idle", out_valid_s, 1'b0);
      in_valid_s = 1'b1;
      sel_s = 2'd1;
      tick();
      check_small("small1", 8'h80, 1'b0, 1'b1, 1'b0);
      sel_s = 2'd2;
      tick();
      check_small("small2", 8'h00, 1'b1, 1'b0, 1'b0);
      sel_s = 2'd3;
      tick();
      check_small("small3", 8'h00, 1'b1, 1'b0, 1'b1);
      sel_s = 2'd0;
      tick();
      check_small("small0", 8'h5a, 1'b0, 1'b0, 1'b0);
      check("small.in_ready", in_ready_s, 1'b1);
      in_valid_s = 1'b0;
      tick();
      check("small.drain", out_valid_s, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
